spi_flash_responder: RTL and testbench

- Synthesizable SPI/QSPI flash target: the device end of the flash bus driven by the SoC's memory-mapped flash controller.
- Lets the SoC boot and execute from an on-chip ROM/BRAM image on boards or benches without a physical flash part.
- Oversamples `spi_clk`, `spi_csb` and `spi_io_i` on a faster local `clk`. It decodes read commands and streams bytes fetched from a byte-wide synchronous memory port.

---
 rtl/spi_flash_responder_pkg.sv | 23 ++
 rtl/spi_flash_sync.sv | 51 +++++
 rtl/spi_flash_responder.sv | 148 ++++++++++++++
 tb/tb_spi_flash_responder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_responder_pkg.sv
// Shared definitions for the SPI flash responder: opcodes, FSM states and
// the continuous-read-mode signature carried in the 0xEB mode byte.
package spi_flash_defs;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FREAD = 8'h0B;
    localparam logic [7:0] OP_QREAD = 8'hEB;
    localparam logic [7:0] OP_WAKE  = 8'hAB;
    localparam logic [7:0] OP_RST   = 8'hFF;

    localparam logic [1:0] CRM_BITS = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        MODE,
        DUMMY,
        DATA,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_flash_sync.sv
// Brings the asynchronous SPI pins into the clk domain and derives SCK edge
// and chip-select start/end pulses from the synchronized values.
module spi_flash_sync (
    input  logic       clk,
    input  logic       resetn,
    input  logic       spi_csb,
    input  logic       spi_clk,
    input  logic [3:0] spi_io_i,
    output logic       csb_s,
    output logic [3:0] io_s,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic       cs_start,
    output logic       cs_end
);

    logic       csb_p0, csb_p1, csb_p2;
    logic       sck_p0, sck_p1, sck_p2;
    logic [3:0] io_p0, io_p1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            csb_p0 <= 1'b1;
            csb_p1 <= 1'b1;
            csb_p2 <= 1'b1;
            sck_p0 <= 1'b0;
            sck_p1 <= 1'b0;
            sck_p2 <= 1'b0;
            io_p0  <= '0;
            io_p1  <= '0;
        end else begin
            csb_p0 <= spi_csb;
            csb_p1 <= csb_p0;
            csb_p2 <= csb_p1;
            sck_p0 <= spi_clk;
            sck_p1 <= sck_p0;
            sck_p2 <= sck_p1;
            io_p0  <= spi_io_i;
            io_p1  <= io_p0;
        end
    end

    // SCK activity only counts while the part is selected
    assign csb_s    = csb_p1;
    assign io_s     = io_p1;
    assign sck_rise =  sck_p1 & ~sck_p2 & ~csb_p1;
    assign sck_fall = ~sck_p1 &  sck_p2 & ~csb_p1;
    assign cs_start = ~csb_p1 &  csb_p2;
    assign cs_end   =  csb_p1 & ~csb_p2;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI/QSPI flash target serving read commands (0x03, 0x0B, 0xEB with
// continuous-read mode) from a byte-wide synchronous memory port.
module spi_flash_responder
    import spi_flash_defs::*;
#(
    parameter int AW     = 16,
    parameter int QDUMMY = 4,
    parameter int FDUMMY = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          spi_csb,
    input  logic          spi_clk,
    input  logic [3:0]    spi_io_i,
    output logic [3:0]    spi_io_o,
    output logic [3:0]    spi_io_oe,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    output logic          busy,
    output logic [7:0]    last_cmd
);

    logic       csb_s, sck_rise, sck_fall, cs_start, cs_end;
    logic [3:0] io_s;

    spi_flash_sync u_sync (
        .clk      (clk),
        .resetn   (resetn),
        .spi_csb  (spi_csb),
        .spi_clk  (spi_clk),
        .spi_io_i (spi_io_i),
        .csb_s    (csb_s),
        .io_s     (io_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_start (cs_start),
        .cs_end   (cs_end)
    );

    state_t      state, state_d;
    logic [4:0]  bit_cnt, phase_len, dummy_len;
    logic [2:0]  out_cnt;
    logic        quad, crm, rd_pend, phase_done;
    logic [23:0] sr_in, sr_next;
    logic [7:0]  sr_out, pre_byte, out_byte;

    always_comb begin
        sr_next  = quad ? {sr_in[19:0], io_s} : {sr_in[22:0], io_s[0]};
        out_byte = (out_cnt == 3'd0) ? pre_byte : sr_out;
        case (state)
            ADDR:    phase_len = quad ? 5'd6 : 5'd24;
            MODE:    phase_len = 5'd2;
            DUMMY:   phase_len = dummy_len;
            default: phase_len = 5'd8;
        endcase
        phase_done = sck_rise && (bit_cnt == phase_len - 5'd1);
    end

    always_comb begin
        state_d = state;
        if (cs_end) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:  if (cs_start) state_d = crm ? ADDR : CMD;
                CMD:   if (phase_done) begin
                    case (sr_next[7:0])
                        OP_READ, OP_FREAD, OP_QREAD: state_d = ADDR;
                        OP_WAKE, OP_RST:             state_d = IGNORE;
                        default:                     state_d = IGNORE;
                    endcase
                end
                ADDR:  if (phase_done) state_d = quad ? MODE : ((dummy_len == 5'd0) ? DATA : DUMMY);
                MODE:  if (phase_done) state_d = (QDUMMY == 0) ? DATA : DUMMY;
                DUMMY: if (phase_done) state_d = DATA;
                default: state_d = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bit_cnt   <= '0;
            out_cnt   <= '0;
            dummy_len <= '0;
            quad      <= 1'b0;
            crm       <= 1'b0;
            rd_pend   <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            spi_io_o  <= '0;
            spi_io_oe <= '0;
            busy      <= 1'b0;
            last_cmd  <= '0;
        end else begin
            mem_rd  <= 1'b0;
            rd_pend <= mem_rd;
            busy    <= ~csb_s;
            if (state_d != state) bit_cnt <= '0;
            else if (sck_rise)    bit_cnt <= bit_cnt + 5'd1;
            if (state == IDLE && cs_start) begin
                quad    <= crm;
                out_cnt <= '0;
            end
            if (state == CMD && phase_done) begin
                last_cmd  <= sr_next[7:0];
                quad      <= (sr_next[7:0] == OP_QREAD);
                dummy_len <= (sr_next[7:0] == OP_FREAD) ? 5'(FDUMMY) : 5'd0;
            end
            if (state == ADDR && phase_done) begin
                mem_addr <= sr_next[AW-1:0];
                mem_rd   <= 1'b1;
            end
            if (state == MODE && phase_done) begin
                crm       <= (sr_next[5:4] == CRM_BITS);
                dummy_len <= 5'(QDUMMY);
            end
            // each byte start consumes the prefetched byte and fetches the next
            if (state == DATA && sck_fall) begin
                if (out_cnt == 3'd0) begin
                    mem_addr  <= mem_addr + AW'(1);
                    mem_rd    <= 1'b1;
                    spi_io_oe <= quad ? 4'b1111 : 4'b0010;
                end
                spi_io_o <= quad ? out_byte[7:4] : {2'b00, out_byte[7], 1'b0};
                out_cnt  <= (out_cnt == (quad ? 3'd1 : 3'd7)) ? 3'd0 : out_cnt + 3'd1;
            end
            if (cs_end) begin
                spi_io_oe <= '0;
                out_cnt   <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sck_rise) sr_in <= sr_next;
        if (rd_pend)  pre_byte <= mem_rdata;
        if (state == DATA && sck_fall)
            sr_out <= quad ? {out_byte[3:0], 4'h0} : {out_byte[6:0], 1'b0};
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: an SPI master model drives transactions and
// returned bytes are compared with a byte-array memory image.
module tb_spi_flash_responder;
    import spi_flash_defs::*;

    localparam int AW     = 16;
    localparam int QDUMMY = 4;
    localparam int FDUMMY = 8;
    localparam int HALF   = 6;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          spi_csb = 1'b1;
    logic          spi_clk = 1'b0;
    logic [3:0]    spi_io_i = 4'h0;
    logic [3:0]    spi_io_o, spi_io_oe;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata = 8'h00;
    logic          busy;
    logic [7:0]    last_cmd;

    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] got [0:7];
    logic [3:0] got_oe [0:7];
    logic [3:0] oe_seen;
    int         checks = 0;
    int         fails = 0;
    int         rd_count = 0;
    int         rd_at_end;

    spi_flash_responder #(.AW(AW), .QDUMMY(QDUMMY), .FDUMMY(FDUMMY)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .spi_csb   (spi_csb),
        .spi_clk   (spi_clk),
        .spi_io_i  (spi_io_i),
        .spi_io_o  (spi_io_o),
        .spi_io_oe (spi_io_oe),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .last_cmd  (last_cmd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= mem[mem_addr];
            rd_count  <= rd_count + 1;
        end
    end

    function automatic logic [7:0] ref_byte(input logic [23:0] a, input int i);
        return mem[AW'(int'(a) + i)];
    endfunction

    task automatic clock_one(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] doe);
        @(negedge clk);
        spi_io_i = din;
        repeat (HALF - 1) @(negedge clk);
        dout    = spi_io_o;
        doe     = spi_io_oe;
        oe_seen = oe_seen | spi_io_oe;
        spi_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic send_bits(input logic [23:0] val, input int n, input bit q);
        logic [3:0] d, e;
        for (int i = n - 1; i >= 0; i--)
            clock_one(q ? val[4*i +: 4] : {3'b000, val[i]}, d, e);
    endtask

    task automatic recv_bytes(input int n, input bit q);
        logic [3:0] d, e;
        logic [7:0] acc;
        for (int b = 0; b < n; b++) begin
            acc = 8'h00;
            for (int k = 0; k < (q ? 2 : 8); k++) begin
                clock_one(4'h0, d, e);
                acc = q ? {acc[3:0], d} : {acc[6:0], d[1]};
            end
            got[b]    = acc;
            got_oe[b] = e;
            rd_at_end = rd_count;
        end
    endtask

    task automatic cs_begin();
        repeat (4) @(negedge clk);
        spi_csb = 1'b0;
        oe_seen = 4'h0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_finish();
        @(negedge clk);
        spi_csb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_read(input bit with_op, input logic [7:0] op, input bit q, input logic [23:0] addr,
                            input bit with_mode, input logic [7:0] mode, input int ndummy,
                            input int nbytes, output int rd_base);
        cs_begin();
        if (with_op) send_bits({16'h0, op}, 8, 1'b0);
        send_bits(addr, q ? 6 : 24, q);
        if (with_mode) send_bits({16'h0, mode}, 2, 1'b1);
        if (ndummy > 0) send_bits(24'h0, ndummy, 1'b0);
        rd_base = rd_count;
        recv_bytes(nbytes, q);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({spi_io_o, spi_io_oe, mem_rd, busy} !== 10'b0) begin
            $display("FAIL reset_outputs: got %b, expected 0", {spi_io_o, spi_io_oe, mem_rd, busy}); fails++;
        end
        checks++;
        if (mem_addr !== '0) begin $display("FAIL reset_mem_addr: got %h, expected 0", mem_addr); fails++; end
        checks++;
        if (last_cmd !== 8'h00) begin $display("FAIL reset_last_cmd: got %h, expected 00", last_cmd); fails++; end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_read();
        int base;
        logic [7:0] exp4 [0:3];
        exp4[0] = 8'hA5; exp4[1] = 8'h5A; exp4[2] = 8'hC3; exp4[3] = 8'h3C;
        for (int i = 0; i < 4; i++) mem[16'h10 + i] = exp4[i];
        run_read(1'b1, OP_READ, 1'b0, 24'h000010, 1'b0, 8'h00, 0, 4, base);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp4[i]) begin $display("FAIL read_byte%0d: got %h, expected %h", i, got[i], exp4[i]); fails++; end
        end
        checks++;
        if (got_oe[0] !== 4'b0010) begin $display("FAIL read_oe: got %b, expected 0010", got_oe[0]); fails++; end
        checks++;
        if (rd_at_end - base !== 4) begin $display("FAIL read_mem_rd_count: got %0d, expected 4", rd_at_end - base); fails++; end
        checks++;
        if (last_cmd !== OP_READ) begin $display("FAIL read_last_cmd: got %h, expected 03", last_cmd); fails++; end
        checks++;
        if (busy !== 1'b1) begin $display("FAIL read_busy: got %b, expected 1", busy); fails++; end
        cs_finish();
        checks++;
        if ({spi_io_oe, busy} !== 5'b0) begin $display("FAIL read_release: got %b, expected 0", {spi_io_oe, busy}); fails++; end
    endtask

    task automatic test_quad_crm();
        int base;
        logic [23:0] a;
        run_read(1'b1, OP_QREAD, 1'b1, 24'h000100, 1'b1, 8'hA0, QDUMMY, 2, base);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got[i] !== ref_byte(24'h100, i)) begin
                $display("FAIL quad_byte%0d: got %h, expected %h", i, got[i], ref_byte(24'h100, i)); fails++;
            end
        end
        checks++;
        if (got_oe[1] !== 4'b1111) begin $display("FAIL quad_oe: got %b, expected 1111", got_oe[1]); fails++; end
        checks++;
        if (last_cmd !== OP_QREAD) begin $display("FAIL quad_last_cmd: got %h, expected eb", last_cmd); fails++; end
        cs_finish();
        run_read(1'b0, 8'h00, 1'b1, 24'h000200, 1'b1, 8'h00, QDUMMY, 1, base);
        checks++;
        if (got[0] !== mem[16'h0200]) begin $display("FAIL crm_byte: got %h, expected %h", got[0], mem[16'h0200]); fails++; end
        cs_finish();
        a = 24'($urandom);
        run_read(1'b1, OP_READ, 1'b0, a, 1'b0, 8'h00, 0, 2, base);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got[i] !== ref_byte(a, i)) begin
                $display("FAIL crm_exit_byte%0d: got %h, expected %h", i, got[i], ref_byte(a, i)); fails++;
            end
        end
        cs_finish();
    endtask

    task automatic test_fast_wrap();
        int base;
        run_read(1'b1, OP_FREAD, 1'b0, 24'h00FFFF, 1'b0, 8'h00, FDUMMY, 2, base);
        checks++;
        if (got[0] !== mem[16'hFFFF]) begin $display("FAIL wrap_byte0: got %h, expected %h", got[0], mem[16'hFFFF]); fails++; end
        checks++;
        if (got[1] !== mem[16'h0000]) begin $display("FAIL wrap_byte1: got %h, expected %h", got[1], mem[16'h0000]); fails++; end
        cs_finish();
    endtask

    task automatic test_ignore();
        int base;
        logic [7:0] ops [0:2];
        logic [23:0] a;
        ops[0] = OP_RST; ops[1] = OP_WAKE; ops[2] = 8'h9F;
        for (int k = 0; k < 3; k++) begin
            cs_begin();
            send_bits({16'h0, ops[k]}, 8, 1'b0);
            recv_bytes(2, 1'b0);
            checks++;
            if (oe_seen !== 4'h0) begin $display("FAIL ignore_oe_%h: got %b, expected 0000", ops[k], oe_seen); fails++; end
            checks++;
            if (last_cmd !== ops[k]) begin $display("FAIL ignore_last_cmd: got %h, expected %h", last_cmd, ops[k]); fails++; end
            cs_finish();
        end
        a = 24'($urandom);
        run_read(1'b1, OP_READ, 1'b0, a, 1'b0, 8'h00, 0, 1, base);
        checks++;
        if (got[0] !== ref_byte(a, 0)) begin $display("FAIL ignore_then_read: got %h, expected %h", got[0], ref_byte(a, 0)); fails++; end
        cs_finish();
    endtask

    task automatic test_abort();
        int base;
        logic [3:0] d, e;
        logic [23:0] a;
        cs_begin();
        send_bits({16'h0, OP_READ}, 8, 1'b0);
        send_bits(24'h000ABC, 12, 1'b0);
        cs_finish();
        checks++;
        if ({spi_io_oe, busy} !== 5'b0) begin $display("FAIL abort_addr_release: got %b, expected 0", {spi_io_oe, busy}); fails++; end
        run_read(1'b1, OP_READ, 1'b0, 24'h001234, 1'b0, 8'h00, 0, 1, base);
        for (int i = 0; i < 4; i++) clock_one(4'h0, d, e);
        checks++;
        if (e !== 4'b0010) begin $display("FAIL abort_data_oe: got %b, expected 0010", e); fails++; end
        cs_finish();
        checks++;
        if ({spi_io_oe, busy} !== 5'b0) begin $display("FAIL abort_data_release: got %b, expected 0", {spi_io_oe, busy}); fails++; end
        a = 24'($urandom);
        run_read(1'b1, OP_READ, 1'b0, a, 1'b0, 8'h00, 0, 2, base);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got[i] !== ref_byte(a, i)) begin
                $display("FAIL abort_recover_byte%0d: got %h, expected %h", i, got[i], ref_byte(a, i)); fails++;
            end
        end
        cs_finish();
    endtask

    task automatic test_reset_mid();
        int base;
        logic [23:0] a;
        run_read(1'b1, OP_QREAD, 1'b1, 24'h000040, 1'b1, 8'hA5, QDUMMY, 1, base);
        cs_finish();
        a = 24'($urandom);
        run_read(1'b0, 8'h00, 1'b1, a, 1'b1, 8'hA0, QDUMMY, 1, base);
        checks++;
        if (got[0] !== ref_byte(a, 0)) begin $display("FAIL rst_crm_byte: got %h, expected %h", got[0], ref_byte(a, 0)); fails++; end
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({spi_io_o, spi_io_oe, mem_rd, busy, mem_addr, last_cmd} !== '0) begin
            $display("FAIL rst_mid_outputs: got %h, expected 0", {spi_io_o, spi_io_oe, mem_rd, busy, mem_addr, last_cmd}); fails++;
        end
        @(negedge clk);
        resetn  = 1'b1;
        spi_csb = 1'b1;
        a = 24'($urandom);
        run_read(1'b1, OP_READ, 1'b0, a, 1'b0, 8'h00, 0, 1, base);
        checks++;
        if (got[0] !== ref_byte(a, 0)) begin $display("FAIL rst_opcode_after: got %h, expected %h", got[0], ref_byte(a, 0)); fails++; end
        checks++;
        if (last_cmd !== OP_READ) begin $display("FAIL rst_last_cmd: got %h, expected 03", last_cmd); fails++; end
        cs_finish();
    endtask

    task automatic test_back_to_back();
        int base, n;
        bit fast;
        logic [23:0] a;
        for (int t = 0; t < 4; t++) begin
            a    = 24'($urandom);
            n    = 1 + int'($urandom_range(2));
            fast = 1'($urandom_range(1));
            run_read(1'b1, fast ? OP_FREAD : OP_READ, 1'b0, a, 1'b0, 8'h00, fast ? FDUMMY : 0, n, base);
            for (int i = 0; i < n; i++) begin
                checks++;
                if (got[i] !== ref_byte(a, i)) begin
                    $display("FAIL b2b_%0d_byte%0d: got %h, expected %h", t, i, got[i], ref_byte(a, i)); fails++;
                end
            end
            cs_finish();
            checks++;
            if (spi_io_oe !== 4'h0) begin $display("FAIL b2b_%0d_release: got %b, expected 0000", t, spi_io_oe); fails++; end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        test_reset();
        test_read();
        test_quad_crm();
        test_fast_wrap();
        test_ignore();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
